// File: rtl/uart_transmitter.sv
// UART frame serialiser: start(0), 8 data bits LSB first, parity, stop(1).
// Each bit is held for CLKS_PER_BIT clocks; all outputs come straight from flops.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TX_start,
  input  logic [7:0] TX_data,
  output logic       TX_out,
  output logic       TX_busy,
  output logic       TX_done
);

  localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic          tx_out_q, tx_out_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          bit_end;

  assign bit_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;

    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (TX_start) begin
          shift_d  = TX_data;
          parity_d = (^TX_data) ^ PARITY_ODD;
          state_d  = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = PARITY;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          // A request in the final stop cycle chains the next frame with no idle gap.
          if (TX_start) begin
            shift_d  = TX_data;
            parity_d = (^TX_data) ^ PARITY_ODD;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are derived from the next state so they land in flops with the state.
  always_comb begin
    tx_out_d = 1'b1;
    case (state_d)
      START:   tx_out_d = 1'b0;
      DATA:    tx_out_d = shift_d[0];
      PARITY:  tx_out_d = parity_d;
      default: tx_out_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (baud_d == BAUD_LAST);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      parity_q <= 1'b0;
      tx_out_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_out_q <= tx_out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign TX_out  = tx_out_q;
  assign TX_busy = busy_q;
  assign TX_done = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: three instances (1 clk/bit even, 1 clk/bit odd,
// 4 clk/bit even) share stimulus; each test observes one of them.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] data;

  logic out0, busy0, done0;
  logic out1, busy1, done1;
  logic out4, busy4, done4;

  int   sel;
  logic o_out, o_busy, o_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_transmitter #(.CLKS_PER_BIT(1), .PARITY_ODD(1'b0)) u_even1 (
    .CLK(clk), .RST(rst), .TX_start(start), .TX_data(data),
    .TX_out(out0), .TX_busy(busy0), .TX_done(done0));

  uart_transmitter #(.CLKS_PER_BIT(1), .PARITY_ODD(1'b1)) u_odd1 (
    .CLK(clk), .RST(rst), .TX_start(start), .TX_data(data),
    .TX_out(out1), .TX_busy(busy1), .TX_done(done1));

  uart_transmitter #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b0)) u_even4 (
    .CLK(clk), .RST(rst), .TX_start(start), .TX_data(data),
    .TX_out(out4), .TX_busy(busy4), .TX_done(done4));

  always_comb begin
    o_out  = out0;
    o_busy = busy0;
    o_done = done0;
    if (sel == 1) begin
      o_out  = out1;
      o_busy = busy1;
      o_done = done1;
    end else if (sel == 2) begin
      o_out  = out4;
      o_busy = busy4;
      o_done = done4;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int s);
    sel   = s;
    rst   = 1'b1;
    start = 1'b0;
    data  = 8'h00;
    step();
    rst = 1'b0;
  endtask

  task automatic check_idle(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      n_checks++;
      if (o_out !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s idle cyc%0d got out/busy/done=%b%b%b want 100",
                 name, i, o_out, o_busy, o_done);
      end
      step();
    end
  endtask

  // Call with the sample point on the first START cycle. Checks every cycle of the
  // frame and decodes it mid-bit like the receiver would.
  task automatic check_frame(input string name, input logic [7:0] d, input int cpb,
                             input bit odd, input int inject_bit, input bit hold,
                             input logic [7:0] next_d, output logic rx_par);
    logic [7:0] rx;
    logic       rx_stop;
    logic       exp;
    rx      = 8'h00;
    rx_par  = 1'b0;
    rx_stop = 1'b0;
    for (int b = 0; b < 11; b++) begin
      if (b == 0)       exp = 1'b0;
      else if (b <= 8)  exp = d[b-1];
      else if (b == 9)  exp = (^d) ^ odd;
      else              exp = 1'b1;
      for (int c = 0; c < cpb; c++) begin
        start = hold;
        if (b == inject_bit && c == 0) begin
          start = 1'b1;
          data  = 8'hFF;
        end
        if (b == 10 && c == cpb - 1) data = next_d;
        else if (b > 0 && inject_bit < 0 && !hold) data = ~d;
        n_checks++;
        if (o_out !== exp) begin
          n_fail++;
          $display("FAIL %s bit%0d cyc%0d tx_out got %b want %b", name, b, c, o_out, exp);
        end
        n_checks++;
        if (o_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s bit%0d cyc%0d tx_busy got %b want 1", name, b, c, o_busy);
        end
        n_checks++;
        if (o_done !== (b == 10 && c == cpb - 1)) begin
          n_fail++;
          $display("FAIL %s bit%0d cyc%0d tx_done got %b want %b", name, b, c, o_done,
                   (b == 10 && c == cpb - 1));
        end
        if (c == cpb / 2) begin
          if (b >= 1 && b <= 8) rx[b-1] = o_out;
          if (b == 9)  rx_par  = o_out;
          if (b == 10) rx_stop = o_out;
        end
        step();
      end
    end
    n_checks++;
    if (rx !== d || (((^rx) ^ odd) !== rx_par) || rx_stop !== 1'b1) begin
      n_fail++;
      $display("FAIL %s loopback got data=%h par=%b stop=%b want data=%h par=%b stop=1",
               name, rx, rx_par, rx_stop, d, (^d) ^ odd);
    end
  endtask

  task automatic test_reset();
    do_reset(0);
    check_idle("reset", 3);
  endtask

  task automatic test_even_a5();
    logic p;
    do_reset(0);
    data  = 8'hA5;
    start = 1'b1;
    step();
    check_frame("even_a5", 8'hA5, 1, 1'b0, -1, 1'b0, 8'h00, p);
    n_checks++;
    if (p !== 1'b0) begin
      n_fail++;
      $display("FAIL even_a5 parity got %b want 0", p);
    end
    check_idle("even_a5_after", 3);
  endtask

  task automatic test_parity();
    logic p;
    do_reset(0);
    data  = 8'h07;
    start = 1'b1;
    step();
    check_frame("even_07", 8'h07, 1, 1'b0, -1, 1'b0, 8'h00, p);
    n_checks++;
    if (p !== 1'b1) begin
      n_fail++;
      $display("FAIL even_07 parity got %b want 1", p);
    end
    do_reset(1);
    data  = 8'hA5;
    start = 1'b1;
    step();
    check_frame("odd_a5", 8'hA5, 1, 1'b1, -1, 1'b0, 8'h00, p);
    n_checks++;
    if (p !== 1'b1) begin
      n_fail++;
      $display("FAIL odd_a5 parity got %b want 1", p);
    end
    check_idle("odd_a5_after", 2);
  endtask

  task automatic test_slow_baud();
    logic p;
    do_reset(2);
    data  = 8'h3C;
    start = 1'b1;
    step();
    check_frame("cpb4_3c", 8'h3C, 4, 1'b0, -1, 1'b0, 8'h00, p);
    check_idle("cpb4_after", 5);
  endtask

  task automatic test_busy_reject();
    logic p;
    do_reset(0);
    data  = 8'h55;
    start = 1'b1;
    step();
    check_frame("reject_55", 8'h55, 1, 1'b0, 4, 1'b0, 8'h00, p);
    check_idle("reject_after", 4);
  endtask

  task automatic test_back_to_back();
    logic p;
    do_reset(0);
    data  = 8'h12;
    start = 1'b1;
    step();
    check_frame("b2b_12", 8'h12, 1, 1'b0, -1, 1'b1, 8'h34, p);
    check_frame("b2b_34", 8'h34, 1, 1'b0, -1, 1'b0, 8'h00, p);
    check_idle("b2b_after", 3);
  endtask

  task automatic test_reset_mid_frame();
    logic p;
    do_reset(0);
    data  = 8'hF0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (o_out !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset got out/busy/done=%b%b%b want 100", o_out, o_busy, o_done);
    end
    step();
    n_checks++;
    if (o_out !== 1'b1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_hold got out/busy=%b%b want 10", o_out, o_busy);
    end
    data  = 8'h81;
    start = 1'b1;
    step();
    check_frame("after_reset_81", 8'h81, 1, 1'b0, -1, 1'b0, 8'h00, p);
    check_idle("after_reset_idle", 2);
  endtask

  initial begin
    sel   = 0;
    rst   = 1'b1;
    start = 1'b0;
    data  = 8'h00;
    test_reset();
    test_even_a5();
    test_parity();
    test_slow_baud();
    test_busy_reject();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
Serial UART frame transmitter that sits directly upstream of the UART receiver and drives its RX_in line. It accepts a parallel byte through a start/busy handshake and serialises it as: start bit (0), 8 data bits LSB first, 1 parity bit, 1 stop bit (1). The line idles high. The frame format is the one the receiver expects. Each bit is held for CLKS_PER_BIT clocks; the default of 1 matches the receiver's one-bit-per-clock sampling.

Parameters:
CLKS_PER_BIT, 1, clock cycles each serial bit is held on TX_out (legal values are 1 or more).
PARITY_ODD, 0, parity sense: 0 = even (parity bit = XOR of data), 1 = odd (parity bit = inverted XOR of data).

Ports:
CLK  input  1  system clock; all logic updates on the rising edge.
RST  input  1  synchronous, active-high reset, sampled on the rising edge of CLK.
TX_start  input  1  request to send TX_data; sampled only when the block can accept a byte.
TX_data  input  8  byte to send; captured in the same cycle TX_start is accepted.
TX_out  output  1  serial line; connects to the receiver's RX_in.
TX_busy  output  1  high while a frame is in progress.
TX_done  output  1  one-cycle pulse in the final cycle of the stop bit.

Behaviour:
- Reset (RST=1 at a clock edge):
  - State goes to IDLE.
  - TX_out=1, TX_busy=0, TX_done=0; bit counter, baud counter and shift register are cleared.
  - Reset takes priority over all other inputs, including in the middle of a frame. The line returns high on the next cycle and the partial frame is abandoned.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_out=1, TX_busy=0.
  - If TX_start=1 at edge k: latch TX_data into the shift register, compute the parity bit from TX_data, go to START.
  - From cycle k+1: TX_out=0 and TX_busy=1.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 in every non-IDLE state.
  - The state or bit advances only when the count reaches CLKS_PER_BIT-1, then the counter wraps to 0.
- START: TX_out=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - TX_out = shift register bit 0; shift right at each bit boundary.
  - The 3-bit index counts 0..7. After bit 7 completes, go to PARITY.
- PARITY: TX_out = stored parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP:
  - TX_out=1 for CLKS_PER_BIT cycles.
  - TX_done=1 during the last cycle of STOP only.
  - If TX_start=0 in that last cycle: go to IDLE; TX_busy drops the next cycle.
  - If TX_start=1 in that last cycle: accept the new byte (latch, compute parity) and go straight to START. TX_busy stays 1 and there is no idle gap (back-to-back frames).
- TX_start at any other time while busy is ignored. The in-flight data is not disturbed.
- TX_data changes after acceptance have no effect.
- Frame length is exactly 11*CLKS_PER_BIT cycles, measured from the first START cycle to the last STOP cycle.
- TX_done is never high for more than 1 consecutive cycle, and never high in IDLE.

Test Plan:
1. Even parity, CLKS_PER_BIT=1: RST, then TX_start=1 with TX_data=8'hA5 for 1 cycle.
   -> TX_out over 11 cycles = 0,1,0,1,0,0,1,0,1,0,1.
   -> TX_busy high for 11 cycles; TX_done pulses on the 11th; then TX_out=1.
2. Parity polarity: TX_data=8'h07 with even parity -> parity bit 1. TX_data=8'hA5 with PARITY_ODD=1 -> parity bit 1.
   Loopback into the receiver for each case -> RX_out matches TX_data, parity_error=0, stop_error=0.
3. CLKS_PER_BIT=4, TX_data=8'h3C -> each bit held 4 cycles; frame is 44 cycles; TX_done is high only in cycle 44.
4. Busy rejection: after a TX_data=8'h55 frame starts, pulse TX_start with 8'hFF in data bit 3.
   -> the serial stream still carries 8'h55; no extra frame follows.
5. Back-to-back: hold TX_start=1 with 8'h12, then 8'h34 presented in the last STOP cycle.
   -> the second start bit immediately follows the stop bit; TX_busy stays continuously 1 for 22 cycles; TX_done pulses twice.
6. Reset mid-frame: assert RST during data bit 4 of 8'hF0.
   -> next cycle TX_out=1, TX_busy=0, TX_done=0.
   -> a following TX_start with 8'h81 produces a clean frame 0,1,0,0,0,0,0,0,1,0,1.
